// File: rtl/font_rom_arbiter.sv
// Shares one synchronous font ROM among NUM_REQ requesters; round-robin, or fixed priority under FONT_ARB_FIXED_PRIO_EN.
// Grant is combinational; response 2+ROM_LAT cycles after grant; never stalls, so requesters must take rsp_valid when it fires.
module font_rom_arbiter #(
  parameter int NUM_REQ  = 2,
  parameter int ROM_LAT  = 1,
  parameter int MAX_WAIT = 8
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*11-1:0]     req_addr,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [10:0]               rom_addr,
  input  logic [7:0]                rom_data,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [7:0]                rsp_data,
  output logic                      busy,
  output logic [NUM_REQ-1:0]        starve
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int NS = ROM_LAT + 1;

  logic                     w_gnt_any;
  logic [IW-1:0]            w_gnt_idx;
  logic [NS-1:0]            r_tag_vld;
  logic [NS-1:0][IW-1:0]    r_tag_idx;
  logic [7:0]               r_wait [NUM_REQ];

`ifdef FONT_ARB_FIXED_PRIO_EN
  always_comb begin
    w_gnt_any = 1'b0;
    w_gnt_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        w_gnt_any = 1'b1;
        w_gnt_idx = IW'(i);
      end
    end
  end
`else
  logic [IW-1:0] r_last;

  // Scan backwards so the requester closest after r_last is the final (winning) assignment.
  always_comb begin
    w_gnt_any = 1'b0;
    w_gnt_idx = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (req[(int'(r_last) + k) % NUM_REQ]) begin
        w_gnt_any = 1'b1;
        w_gnt_idx = IW'((int'(r_last) + k) % NUM_REQ);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_last <= IW'(NUM_REQ - 1);
    end else if (w_gnt_any) begin
      r_last <= w_gnt_idx;
    end
  end
`endif

  always_comb begin
    gnt = NUM_REQ'(w_gnt_any) << w_gnt_idx;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rom_addr <= '0;
    end else if (w_gnt_any) begin
      rom_addr <= req_addr[11*w_gnt_idx +: 11];
    end
  end

  // Stage s holds the owner of the lookup whose address went out s+1 cycles ago.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tag_vld <= '0;
      r_tag_idx <= '0;
    end else begin
      r_tag_vld[0] <= w_gnt_any;
      r_tag_idx[0] <= w_gnt_idx;
      for (int s = 1; s < NS; s++) begin
        r_tag_vld[s] <= r_tag_vld[s-1];
        r_tag_idx[s] <= r_tag_idx[s-1];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_valid <= '0;
      rsp_data  <= '0;
    end else if (r_tag_vld[NS-1]) begin
      rsp_valid <= NUM_REQ'(1) << r_tag_idx[NS-1];
      rsp_data  <= rom_data;
    end else begin
      rsp_valid <= '0;
    end
  end

  always_comb begin
    busy = |r_tag_vld;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      starve <= '0;
      for (int i = 0; i < NUM_REQ; i++) r_wait[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req[i] && !gnt[i]) begin
          if (r_wait[i] < 8'(MAX_WAIT)) r_wait[i] <= r_wait[i] + 8'd1;
          if (r_wait[i] >= 8'(MAX_WAIT - 1)) starve[i] <= 1'b1;
        end else begin
          r_wait[i] <= '0;
        end
      end
    end
  end

endmodule

// File: doc/font_rom_arbiter.md
Name: font_rom_arbiter

Overview:
- Shares the single synchronous font ROM (8-bit rows, 11-bit address = {char 7b, row 4b}) between several requesters, e.g. the on-screen text generator and a cursor/overlay renderer.
- One ROM lookup is granted per clock: round-robin by default, fixed priority when the optional feature is compiled in.
- Tracks in-flight lookups and returns ROM data tagged to the owning requester.
- Flags requesters that wait too long for a grant.

Parameters:
- NUM_REQ, 2, number of requesters (2..4); index 0 is the pixel-timing-critical text path.
- ROM_LAT, 1, font ROM read latency in cycles from the cycle rom_addr is presented to rom_data valid.
- MAX_WAIT, 8, consecutive denied cycles after which a requester's starve bit is set (1..255).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- req  in  NUM_REQ  per-requester lookup request; held with its address until granted.
- req_addr  in  NUM_REQ*11  flattened addresses; requester i occupies bits [11*i+10:11*i].
- gnt  out  NUM_REQ  one-hot grant, combinational from req and the arbitration pointer; at most one bit high.
- rom_addr  out  11  registered address to font ROM.
- rom_data  in  8  font ROM row word.
- rsp_valid  out  NUM_REQ  one-hot registered response strobe.
- rsp_data  out  8  registered ROM row for the requester flagged in rsp_valid.
- busy  out  1  high while any lookup is in flight.
- starve  out  NUM_REQ  sticky starvation flags.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (reset_n).
- Reset values:
  - gnt=0, rom_addr=0, rsp_valid=0, rsp_data=0, busy=0, starve=0.
  - All wait counters = 0; tag pipeline empty.
  - Round-robin pointer last=NUM_REQ-1, so requester 0 wins the first contention.
- Arbitration (cycle T):
  - Scan from last+1 upward, wrapping modulo NUM_REQ.
  - The first i with req[i]=1 gets gnt[i]=1 in T; last<=i at end of T.
  - No request: gnt=0 and last is unchanged.
- Request protocol:
  - A requester keeps req and its address stable until it sees gnt.
  - A grant consumes exactly one request; req still high in T+1 counts as a new request.
  - Address changes while req is high and ungranted are legal; the address sampled is the one present in the grant cycle.
- Pipeline for a grant in cycle T:
  - rom_addr <= granted address at end of T, presented during T+1.
  - ROM data valid in cycle T+1+ROM_LAT.
  - rsp_data/rsp_valid registered at the end of that cycle, visible in T+2+ROM_LAT (T+3 for default).
  - rsp_valid is high for exactly one cycle.
  - Throughput is one lookup per cycle; back-to-back grants produce back-to-back responses in grant order.
- Tag pipeline:
  - ROM_LAT+1 stages, each a valid bit plus requester index.
  - Shifts every cycle and never stalls; requesters must accept responses when rsp_valid is asserted.
- busy: OR of all tag-stage valid bits.
- rom_addr holds its last value when no grant is issued.
- Wait counters, 8-bit per requester:
  - Increment when req[i]=1 and gnt[i]=0.
  - Clear on gnt[i] or when req[i]=0.
  - Saturate at MAX_WAIT.
  - starve[i] sets on reaching MAX_WAIT and stays set until reset.
- Reset mid-operation: all in-flight tags are discarded immediately. No rsp_valid is issued for lookups granted before reset, even if ROM data arrives later.
- NUM_REQ=1: gnt=req, with the same latency.

Optional Feature:
- Macro: FONT_ARB_FIXED_PRIO_EN.
- Defined:
  - Fixed priority, lowest index wins; pointer logic removed.
  - Requester 0 is always granted in the cycle it requests, so starve[0] can never set.
- Undefined: round-robin as described above.

Test Plan:
- Single lookup: req=2'b01, req_addr[10:0]=11'h4A3 at cycle 5 -> gnt[0] cycle 5; rom_addr=11'h4A3 cycle 6; rsp_valid=2'b01 cycle 8 with rsp_data = ROM row (J, row 3).
- Contention (round-robin build): req=2'b11 held continuously from reset -> grants alternate 01,10,01,10; responses return in the same order 3 cycles later; rsp_valid is never two-hot.
- Starvation (FONT_ARB_FIXED_PRIO_EN build): req[0] held high for 10 cycles with req[1] high -> req[1] never granted; starve[1] sets at the 8th denied cycle and stays 1 after req drops.
- Reset mid-flight: grant at cycle 10, reset_n low at cycle 11 for 1 cycle -> rsp_valid stays 0 through cycle 20; busy=0 from the reset assertion.
- Back-to-back throughput: req[1] held high for 16 cycles with distinct addresses 11'h470..11'h47F -> 16 consecutive rsp_valid=2'b10 with matching data; busy high throughout.
- Idle hold: no requests after the last grant -> rom_addr unchanged, gnt=0, pointer unchanged; the next req=2'b11 is granted to index (last+1) mod 2.
